// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/retire control for the 32x32 signed multiplier array.
// Define MUL_ZERO_BYPASS_EN to retire zero-operand ops without waiting on the array.
module mul_issue_ctrl #(
    parameter int MUL_LAT = 0,
    parameter int TAG_W   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [63:0]      mul_p,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [1:0] LAT = 2'(MUL_LAT);

    state_t           state;
    state_t           state_nx;
    logic [1:0]       count;
    logic [1:0]       op;
    logic [TAG_W-1:0] tag;
    logic             accept;
    logic             zero_op;
    logic [63:0]      prod;
    logic [31:0]      result;

`ifdef MUL_ZERO_BYPASS_EN
    assign zero_op = (in_a == 32'h0) || (in_b == 32'h0);
`else
    assign zero_op = 1'b0;
`endif

    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        accept   = 1'b0;
        unique case (state)
            IDLE:    in_ready = !flush;
            DONE:    in_ready = out_ready && !flush;
            default: in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = zero_op ? DONE : CALC;
            end
            CALC: begin
                if (count == 2'd0) state_nx = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    if (accept) state_nx = zero_op ? DONE : CALC;
                    else        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    // Signed product is fixed up into s*u / u*u by adding the sign-bit cross terms.
    always_comb begin
        prod = mul_p;
        if ((op == 2'b10 || op == 2'b11) && mul_b[31]) begin
            prod = prod + {mul_a, 32'h0};
        end
        if (op == 2'b11 && mul_a[31]) begin
            prod = prod + {mul_b, 32'h0};
        end
        result = (op == 2'b00) ? prod[31:0] : prod[63:32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a    <= 32'h0;
            mul_b    <= 32'h0;
            op       <= 2'b00;
            tag      <= '0;
            count    <= 2'd0;
            out_data <= 32'h0;
            out_tag  <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else if (accept) begin
            mul_a <= in_a;
            mul_b <= in_b;
            op    <= in_op;
            tag   <= in_tag;
            count <= LAT;
            if (zero_op) begin
                out_data <= 32'h0;
                out_tag  <= in_tag;
            end
        end else if (state == CALC) begin
            if (count != 2'd0) begin
                count <= count - 2'd1;
            end else begin
                out_data <= result;
                out_tag  <= tag;
            end
        end
    end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Issue/retire controller between the MCU execute stage and the 32x32 signed Booth/Wallace multiplier array.
- Accepts one multiply op per valid/ready handshake and registers the operands onto the array inputs.
- Counts the array's pipeline latency, then applies the unsigned/mixed-sign high-word correction to the signed 64-bit product.
- Returns a 32-bit result plus destination tag to writeback over a valid/ready handshake.

Parameters:
- MUL_LAT, 0, register stages inside the attached array (0..3); must equal the array's PIPELINE setting.
- TAG_W, 5, width of the destination-register tag carried with each op.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  pipeline kill; synchronous; aborts any op held or in flight.
- in_valid  in  1  op request valid.
- in_ready  out  1  controller can accept an op this cycle.
- in_op  in  2  00=MUL (low word), 01=MULH (s*s), 10=MULHSU (s*u), 11=MULHU (u*u).
- in_a  in  32  operand rs1.
- in_b  in  32  operand rs2.
- in_tag  in  TAG_W  destination tag.
- mul_a  out  32  registered operand A to the array.
- mul_b  out  32  registered operand B to the array.
- mul_p  in  64  signed product from the array.
- out_valid  out  1  result valid.
- out_ready  in  1  writeback accepts the result.
- out_data  out  32  result word.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset: state=IDLE; out_valid=0; out_data=0; out_tag=0; mul_a=0; mul_b=0; count=0; busy=0.
- Reset asserted mid-operation discards the op; no result is emitted.
- FSM IDLE:
  - in_ready=1.
  - Accept when in_valid && !flush: load mul_a/mul_b/op/tag, set count=MUL_LAT, go to CALC.
- FSM CALC:
  - in_ready=0.
  - If count!=0: decrement count.
  - If count==0: register the corrected result into out_data/out_tag, set out_valid=1, go to DONE.
- FSM DONE:
  - out_valid=1; out_data and out_tag are held stable until the handshake.
  - in_ready=out_ready, so back-to-back issue is allowed.
  - On out_ready: out_valid drops next cycle. If a new op is accepted in the same cycle, go to CALC; otherwise go to IDLE.
- Latency: out_valid rises exactly MUL_LAT+1 cycles after the accept edge. Throughput is one op per MUL_LAT+2 cycles under a continuously asserted out_ready.
- Correction, all sums mod 2^64 with P=mul_p:
  - MUL and MULH: P unchanged.
  - MULHSU: P + (b[31] ? a<<32 : 0).
  - MULHU: P + (a[31] ? b<<32 : 0) + (b[31] ? a<<32 : 0).
  - MUL returns bits [31:0]; the others return bits [63:32].
- flush has priority over everything except reset.
  - Next cycle: state=IDLE, out_valid=0, count=0.
  - An in_valid presented in the same cycle is not accepted; in_ready is forced low while flush=1.
  - A DONE result dropped by flush is never re-presented.
- mul_a/mul_b hold their last value while IDLE; they change only on accept.
- Op encoding is always one of the four defined ops; no illegal-op handling.

Optional Feature:
- Macro MUL_ZERO_BYPASS_EN.
- Defined: on accept, if in_a==0 or in_b==0, go straight to DONE with out_data=0 on the next edge, so out_valid rises 1 cycle after accept regardless of MUL_LAT. mul_a/mul_b still load.
- Undefined: zero operands take the normal MUL_LAT+1 path. Results are identical either way; only latency differs.

Test Plan:
- MUL_LAT=2, out_ready=1: MUL a=7, b=0xFFFFFFFD -> out_data=0xFFFFFFEB exactly 3 cycles after accept, out_tag echoed.
- MULH a=b=0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU same operands -> 0xFFFFFFFF.
- Back-to-back: two ops with out_ready=1 -> second accepted in the DONE handshake cycle, results in order, no bubble beyond MUL_LAT+2 spacing.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_data, out_tag stable and in_ready=0; release -> single transfer.
- flush during CALC, and flush together with in_valid in IDLE -> no out_valid, state IDLE next cycle, in_ready=0 during flush.
- rst_n pulsed low mid-CALC -> all outputs 0 immediately. With MUL_ZERO_BYPASS_EN, MULHU a=0, b=0x80000000 -> out_data=0 one cycle after accept.
